accum_arbiter: RTL and testbench
================================

Name: accum_arbiter

Overview:
- Shares one align-and-accumulate datapath between NREQ requesters.
- Each requester offers a WIDTH-bit word on a valid/ready handshake. Winners are chosen round-robin.
- For each granted word, the block sequences load, then align, then accumulate into a shared accumulator.
- Sits between multiple producers and the single accumulator resource. It reports a completion pulse tagged with the winner's index.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data and accumulator width in bits.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester valid.
- req_data  input  NREQ*WIDTH  per-requester word; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot grant/accept; combinational from state and req_valid.
- clear  input  1  synchronous accumulator clear.
- acc_out  output  WIDTH  registered accumulator value.
- done  output  1  one-cycle pulse: acc_out updated this cycle.
- done_id  output  clog2(NREQ) (min 1)  index of the requester whose word produced done.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; acc_out=0; buffer=0; done=0; done_id=0; busy=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - req_ready=0 while reset_n is low.
- States: IDLE, ALIGN, ACC.
- IDLE:
  - If any req_valid is high, grant the first valid index searching upward from last_grant+1, wrapping mod NREQ.
  - Drive req_ready one-hot for that index in the same cycle. The handshake completes that cycle.
  - On the edge: buffer <= granted data; grant <= index; last_grant <= index; state <= ALIGN.
  - req_ready is 0 in ALIGN and ACC, and 0 in IDLE when no valid is high.
- ALIGN:
  - If buffer[1:0] != 0: buffer <= buffer+1, modulo 2^WIDTH. 0xFF wraps to 0x00 for WIDTH=8.
  - Otherwise: state <= ACC.
- ACC:
  - acc_out <= acc_out + buffer (width rule per the optional feature).
  - done <= 1; done_id <= grant; state <= IDLE.
- done is high for exactly one cycle, coincident with the new acc_out. It is 0 in every other cycle.
- Latency, with handshake in cycle T and k = (4 - data[1:0]) mod 4:
  - ALIGN occupies k+1 cycles.
  - ACC occupies cycle T+k+2.
  - done is high in cycle T+k+3.
  - The next grant can occur in cycle T+k+3, the IDLE cycle in which done is high.
- Fairness: a requester that holds valid is granted within NREQ grants.
- Requesters must hold req_valid and req_data stable until their req_ready. Dropping valid before grant is permitted and simply forfeits the slot.
- clear:
  - Accepted in any state.
  - In IDLE or ALIGN: acc_out <= 0.
  - Coinciding with ACC: acc_out <= buffer. Clear applies first, then the add; done still pulses.
  - clear does not affect the handshake, buffer, or the FSM.
- reset_n asserted mid-operation: the in-flight word is discarded, with no done; every output returns to its reset value.

Optional Feature:
- Macro: ACCUM_ARBITER_SATURATE_EN.
- Defined: the ACC add saturates. If the true sum is >= 2^WIDTH, acc_out <= all-ones; once saturated, it stays all-ones until clear or reset.
- Undefined: the add wraps modulo 2^WIDTH.
- Handshake, latency, and done timing are identical in both builds.

Test Plan:
- Reset then single request: req_valid=0001, data0=0x04 -> req_ready=0001 in cycle T; done=1 at T+3 with acc_out=0x04, done_id=0.
- Alignment wrap: data0=0xFD -> aligned value 0x00 after 3 increments; done at T+6; acc_out unchanged from its prior value.
- Round-robin: all four valid continuously, each with data 0x04 -> grant order 0,1,2,3,0; acc_out after four done pulses = 0x10.
- Wrap vs saturate: acc_out=0xF8, request data 0x10 -> without macro acc_out=0x08; with ACCUM_ARBITER_SATURATE_EN acc_out=0xFF.
- clear coincident with ACC: acc_out=0x20, buffer=0x08 in ACC, clear=1 -> acc_out=0x08 and done=1 the next cycle.
- reset_n pulled low during ALIGN -> done never pulses, req_ready=0, acc_out=0; after release, requester 0 has first priority.

Source files
------------

// File: rtl/accum_arbiter_if.sv
// Requester-side handshake bundle for accum_arbiter.
// The producers drive valid/data through master; the arbiter returns a one-hot ready through slave.
interface accum_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;

    modport master (output req_valid, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/accum_arbiter.sv
// Round-robin arbiter feeding a shared align-and-accumulate datapath.
// Define ACCUM_ARBITER_SATURATE_EN to make the accumulator saturate instead of wrapping.
module accum_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    accum_arbiter_if.slave       req,
    input  logic                 clear,
    output logic [WIDTH-1:0]     acc_out,
    output logic                 done,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] done_id,
    output logic                 busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // state | meaning
    // IDLE  | waiting for a valid requester; grant and capture in the same cycle
    // ALIGN | increment the buffered word until its low two bits are zero
    // ACC   | add buffered word into the accumulator, pulse done next cycle
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_ACC   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  buf_q, buf_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     done_id_q, done_id_d;
    logic              done_q, done_d;

    logic [IW-1:0]     pick;
    logic [IW-1:0]     cand;
    logic              any_valid;
    logic [NREQ-1:0]   ready;
    logic [WIDTH-1:0]  acc_base;
    logic [WIDTH-1:0]  acc_sum;

    // Scan downward so the last hit is the nearest index after last_q.
    always_comb begin
        pick      = '0;
        cand      = '0;
        any_valid = 1'b0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IW'((int'(last_q) + off) % NREQ);
            if (req.req_valid[cand]) begin
                pick      = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (reset_n && (state_q == S_IDLE) && any_valid) begin
            ready[pick] = 1'b1;
        end
    end

    assign req.req_ready = ready;

    // Clear takes effect before the add when both land in the same cycle.
    assign acc_base = clear ? '0 : acc_q;

`ifdef ACCUM_ARBITER_SATURATE_EN
    logic [WIDTH:0] sum_wide;
    assign sum_wide = {1'b0, acc_base} + {1'b0, buf_q};
    assign acc_sum  = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
`else
    assign acc_sum  = acc_base + buf_q;
`endif

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        grant_d   = grant_q;
        last_d    = last_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        acc_d     = acc_base;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    buf_d   = req.req_data[int'(pick)*WIDTH +: WIDTH];
                    grant_d = pick;
                    last_d  = pick;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (buf_q[1:0] != 2'b00) begin
                    buf_d = buf_q + WIDTH'(1);
                end else begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d     = acc_sum;
                done_d    = 1'b1;
                done_id_d = grant_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            acc_q     <= '0;
            grant_q   <= '0;
            last_q    <= IW'(NREQ - 1);
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            acc_q     <= acc_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign acc_out = acc_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_accum_arbiter.sv
// Self-checking bench for accum_arbiter: directed scenarios plus a randomized run
// against a latency/arithmetic reference model.
module tb_accum_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IW    = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] acc_out;
    logic             done;
    logic [IW-1:0]    done_id;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    accum_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    accum_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.slave),
        .clear   (clear),
        .acc_out (acc_out),
        .done    (done),
        .done_id (done_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH-1:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int s;
        s = int'(a) + int'(b);
`ifdef ACCUM_ARBITER_SATURATE_EN
        if (s >= 256) return 8'hFF;
`endif
        return WIDTH'(s);
    endfunction

    function automatic int ref_k(input logic [WIDTH-1:0] d);
        return (4 - (int'(d) % 4)) % 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        clear         = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Single-requester transaction; lat = cycles from handshake to done, -1 on timeout.
    task automatic txn(input int idx, input logic [WIDTH-1:0] d, output int lat,
                       output logic [WIDTH-1:0] acc, output logic [IW-1:0] id);
        int w;
        lat = -1;
        acc = '0;
        id  = '0;
        bus.req_valid[idx] = 1'b1;
        bus.req_data[idx*WIDTH +: WIDTH] = d;
        w = 0;
        #1;
        while (bus.req_ready[idx] !== 1'b1 && w < 20) begin
            tick();
            #1;
            w++;
        end
        if (w >= 20) begin
            bus.req_valid[idx] = 1'b0;
            return;
        end
        tick();
        bus.req_valid[idx] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (done === 1'b1) begin
                lat = c;
                acc = acc_out;
                id  = done_id;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.req_valid = '1;
        bus.req_data  = '0;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
        n_vec++; if (acc_out !== 8'h00) begin n_err++; $display("FAIL reset_acc: got %h expected 00", acc_out); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (done_id !== 2'd0) begin n_err++; $display("FAIL reset_done_id: got %0d expected 0", done_id); end
        bus.req_valid = '0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: WIDTH] = 8'h04;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        for (int c = 1; c <= 6; c++) begin
            n_vec++; if (done !== (c == 3)) begin n_err++; $display("FAIL single_done c=%0d: got %b expected %b", c, done, (c == 3)); end
            n_vec++; if (busy !== (c < 3)) begin n_err++; $display("FAIL single_busy c=%0d: got %b expected %b", c, busy, (c < 3)); end
            if (c == 3) begin
                n_vec++; if (acc_out !== 8'h04) begin n_err++; $display("FAIL single_acc: got %h expected 04", acc_out); end
                n_vec++; if (done_id !== 2'd0) begin n_err++; $display("FAIL single_id: got %0d expected 0", done_id); end
            end
            tick();
        end
    endtask

    task automatic test_align_wrap();
        int lat;
        logic [WIDTH-1:0] acc;
        logic [IW-1:0] id;
        txn(0, 8'hFD, lat, acc, id);
        n_vec++; if (lat !== 6) begin n_err++; $display("FAIL wrap_latency: got %0d expected 6", lat); end
        n_vec++; if (acc !== 8'h04) begin n_err++; $display("FAIL wrap_acc: got %h expected 04", acc); end
        n_vec++; if (id !== 2'd0) begin n_err++; $display("FAIL wrap_id: got %0d expected 0", id); end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int gi = 0;
        int dn = 0;
        do_reset();
        bus.req_valid = '1;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 8'h04;
        for (int c = 0; c < 16; c++) begin
            if (done === 1'b1 && dn < 4) begin
                n_vec++; if (done_id !== IW'(order[dn])) begin n_err++; $display("FAIL rr_done_id #%0d: got %0d expected %0d", dn, done_id, order[dn]); end
                dn++;
                if (dn == 4) begin
                    n_vec++; if (acc_out !== 8'h10) begin n_err++; $display("FAIL rr_acc: got %h expected 10", acc_out); end
                end
            end
            #1;
            if (bus.req_ready !== 4'b0000 && gi < 5) begin
                n_vec++; if (bus.req_ready !== (4'b0001 << order[gi])) begin n_err++; $display("FAIL rr_grant #%0d: got %b expected %b", gi, bus.req_ready, 4'b0001 << order[gi]); end
                gi++;
            end
            tick();
        end
        bus.req_valid = '0;
        n_vec++; if (gi !== 5) begin n_err++; $display("FAIL rr_grant_count: got %0d expected 5", gi); end
        n_vec++; if (dn !== 4) begin n_err++; $display("FAIL rr_done_count: got %0d expected 4", dn); end
        for (int c = 0; c < 6; c++) tick();
    endtask

    task automatic test_wrap_sat();
        int lat;
        logic [WIDTH-1:0] acc;
        logic [IW-1:0] id;
        logic [WIDTH-1:0] exp1, exp2;
`ifdef ACCUM_ARBITER_SATURATE_EN
        exp1 = 8'hFF;
        exp2 = 8'hFF;
`else
        exp1 = 8'h08;
        exp2 = 8'h0C;
`endif
        do_reset();
        txn(1, 8'hF8, lat, acc, id);
        n_vec++; if (acc !== 8'hF8) begin n_err++; $display("FAIL sat_pre: got %h expected F8", acc); end
        txn(2, 8'h10, lat, acc, id);
        n_vec++; if (acc !== exp1) begin n_err++; $display("FAIL sat_overflow: got %h expected %h", acc, exp1); end
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL sat_latency: got %0d expected 3", lat); end
        txn(3, 8'h04, lat, acc, id);
        n_vec++; if (acc !== exp2) begin n_err++; $display("FAIL sat_hold: got %h expected %h", acc, exp2); end
        n_vec++; if (id !== 2'd3) begin n_err++; $display("FAIL sat_id: got %0d expected 3", id); end
    endtask

    task automatic test_clear();
        int lat;
        logic [WIDTH-1:0] acc;
        logic [IW-1:0] id;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_vec++; if (acc_out !== 8'h00) begin n_err++; $display("FAIL clear_idle: got %h expected 00", acc_out); end
        txn(0, 8'h20, lat, acc, id);
        n_vec++; if (acc !== 8'h20) begin n_err++; $display("FAIL clear_pre: got %h expected 20", acc); end
        // clear landing in the ACC cycle: result is just the buffered word
        bus.req_valid[1] = 1'b1;
        bus.req_data[1*WIDTH +: WIDTH] = 8'h08;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL clear_ready: got %b expected 0010", bus.req_ready); end
        tick();
        bus.req_valid[1] = 1'b0;
        tick();
        clear = 1'b1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_acc_busy: got %b expected 1", busy); end
        tick();
        clear = 1'b0;
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL clear_acc_done: got %b expected 1", done); end
        n_vec++; if (acc_out !== 8'h08) begin n_err++; $display("FAIL clear_acc_value: got %h expected 08", acc_out); end
        tick();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL clear_done_single: got %b expected 0", done); end
        // clear during ALIGN zeroes acc; the word still lands afterwards
        bus.req_valid[2] = 1'b1;
        bus.req_data[2*WIDTH +: WIDTH] = 8'h11;
        tick();
        bus.req_valid[2] = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_vec++; if (acc_out !== 8'h00) begin n_err++; $display("FAIL clear_align: got %h expected 00", acc_out); end
        for (int c = 2; c <= 6; c++) begin
            if (c == 6) begin
                n_vec++; if (done !== 1'b1 || acc_out !== 8'h14) begin n_err++; $display("FAIL clear_align_result: got done=%b acc=%h expected done=1 acc=14", done, acc_out); end
            end
            if (c < 6) tick();
        end
    endtask

    task automatic test_reset_mid();
        bus.req_valid[3] = 1'b1;
        bus.req_data[3*WIDTH +: WIDTH] = 8'h01;
        #1;
        n_vec++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL rmid_ready: got %b expected 1000", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        tick();
        reset_n = 1'b0;
        bus.req_valid = '1;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL rmid_ready_low: got %b expected 0000", bus.req_ready); end
        n_vec++; if (acc_out !== 8'h00) begin n_err++; $display("FAIL rmid_acc: got %h expected 00", acc_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        tick();
        tick();
        bus.req_valid = '0;
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_no_done c=%0d: got %b expected 0", c, done); end
            tick();
        end
        bus.req_valid = '1;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_priority: got %b expected 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        for (int c = 0; c < 6; c++) tick();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] m_acc, m_aligned, nxt;
        logic [WIDTH-1:0] pdata[NREQ];
        logic [NREQ-1:0]  pend, exp_ready;
        logic [IW-1:0]    m_id;
        int m_last, done_at, t_grant, g;
        logic clr, idle, found;
        do_reset();
        m_acc = '0; m_aligned = '0; m_id = '0;
        pend = '0; m_last = NREQ - 1; done_at = -1; t_grant = -1;
        for (int i = 0; i < NREQ; i++) pdata[i] = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            n_vec++; if (done !== (cyc == done_at)) begin n_err++; $display("FAIL rnd_done cyc=%0d: got %b expected %b", cyc, done, (cyc == done_at)); end
            if (cyc == done_at) begin
                n_vec++; if (done_id !== m_id) begin n_err++; $display("FAIL rnd_done_id cyc=%0d: got %0d expected %0d", cyc, done_id, m_id); end
            end
            n_vec++; if (acc_out !== m_acc) begin n_err++; $display("FAIL rnd_acc cyc=%0d: got %h expected %h", cyc, acc_out, m_acc); end
            n_vec++; if (busy !== (cyc > t_grant && cyc < done_at)) begin n_err++; $display("FAIL rnd_busy cyc=%0d: got %b expected %b", cyc, busy, (cyc > t_grant && cyc < done_at)); end
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = WIDTH'($urandom);
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
                bus.req_valid[i] = pend[i];
                bus.req_data[i*WIDTH +: WIDTH] = pdata[i];
            end
            clr = ($urandom_range(0, 9) == 0);
            clear = clr;
            #1;
            idle = (cyc >= done_at);
            exp_ready = '0;
            g = 0;
            found = 1'b0;
            if (idle) begin
                for (int o = 1; o <= NREQ; o++) begin
                    int j;
                    j = (m_last + o) % NREQ;
                    if (pend[j] && !found) begin
                        g = j;
                        found = 1'b1;
                    end
                end
                if (found) exp_ready[g] = 1'b1;
            end
            n_vec++; if (bus.req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready cyc=%0d: got %b expected %b", cyc, bus.req_ready, exp_ready); end
            nxt = clr ? '0 : m_acc;
            if (cyc == done_at - 1) nxt = ref_add(nxt, m_aligned);
            if (found) begin
                m_aligned = WIDTH'(int'(pdata[g]) + ref_k(pdata[g]));
                t_grant   = cyc;
                done_at   = cyc + ref_k(pdata[g]) + 3;
                m_id      = IW'(g);
                m_last    = g;
                pend[g]   = 1'b0;
            end
            tick();
            m_acc = nxt;
        end
        bus.req_valid = '0;
        clear = 1'b0;
        for (int c = 0; c < 8; c++) tick();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        test_reset();
        test_single();
        test_align_wrap();
        test_round_robin();
        test_wrap_sat();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
